// File: rtl/mant_mult_seq_if.sv
// Operand/product handshake bundle for the sequential mantissa multiplier.
// master = upstream/downstream side (driver), slave = the multiplier itself.
interface mant_mult_seq_if #(
    parameter int WIDTH = 24
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a_mant;
    logic [WIDTH-1:0]     b_mant;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   product;
    logic                 busy;

    modport master (
        output in_valid, a_mant, b_mant, out_ready,
        input  in_ready, out_valid, product, busy
    );

    modport slave (
        input  in_valid, a_mant, b_mant, out_ready,
        output in_ready, out_valid, product, busy
    );
endinterface

// File: rtl/mant_mult_seq.sv
// Sequential mantissa multiplier: one partial product per cycle into a carry-save
// pair, then a single carry-propagate add. Optional macro: MANT_MULT_EARLY_TERM_EN.
module mant_mult_seq #(
    parameter int WIDTH = 24
) (
    input  logic            clk,
    input  logic            rst,
    mant_mult_seq_if.slave  bus
);
    localparam int PW = 2 * WIDTH;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REDUCE,
        S_RESOLVE,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b_sh;
    logic [CW-1:0]    r_count;
    logic [PW-1:0]    r_sum;
    logic [PW-1:0]    r_carry;
    logic [PW-1:0]    r_product;
    logic [PW-1:0]    w_pp;
    logic [PW-1:0]    w_maj;
    logic [PW-1:0]    w_sum_nxt;
    logic [PW-1:0]    w_carry_nxt;
    logic             w_last;
    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_busy;

    // One 3:2 compressor row: the majority bits become the carry vector, weighted x2.
    assign w_pp        = r_b_sh[0] ? ({{WIDTH{1'b0}}, r_a} << r_count) : '0;
    assign w_sum_nxt   = r_sum ^ r_carry ^ w_pp;
    assign w_maj       = (r_sum & r_carry) | (r_sum & w_pp) | (r_carry & w_pp);
    assign w_carry_nxt = {w_maj[PW-2:0], 1'b0};

`ifdef MANT_MULT_EARLY_TERM_EN
    assign w_last = (r_count == CW'(WIDTH - 1)) || ((r_b_sh >> 1) == '0);
`else
    assign w_last = (r_count == CW'(WIDTH - 1));
`endif

    // NOTE: state and datapath registers use non-blocking assignments so every
    // flop samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        w_busy      = 1'b1;
        case (r_state)
            S_IDLE: begin
                w_in_ready = 1'b1;
                w_busy     = 1'b0;
                if (bus.in_valid) w_state_nxt = S_REDUCE;
            end
            S_REDUCE: begin
                if (w_last) w_state_nxt = S_RESOLVE;
            end
            S_RESOLVE: begin
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a       <= '0;
            r_b_sh    <= '0;
            r_count   <= '0;
            r_sum     <= '0;
            r_carry   <= '0;
            r_product <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_a     <= bus.a_mant;
                        r_b_sh  <= bus.b_mant;
                        r_count <= '0;
                        r_sum   <= '0;
                        r_carry <= '0;
                    end
                end
                S_REDUCE: begin
                    r_sum   <= w_sum_nxt;
                    r_carry <= w_carry_nxt;
                    r_b_sh  <= r_b_sh >> 1;
                    r_count <= r_count + CW'(1);
                end
                S_RESOLVE: begin
                    r_product <= r_sum + r_carry;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.busy      = w_busy;
    assign bus.product   = r_product;
endmodule

// File: tb/tb_mant_mult_seq.sv
// Self-checking bench for mant_mult_seq: directed test-plan cases plus random
// operands against a plain-arithmetic multiply/latency model.
module tb_mant_mult_seq;
    localparam int W  = 24;
    localparam int PW = 2 * W;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    mant_mult_seq_if #(.WIDTH(W)) bus ();

    mant_mult_seq #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [PW-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [PW-1:0] aa;
        logic [PW-1:0] bb;
        aa = {{W{1'b0}}, a};
        bb = {{W{1'b0}}, b};
        return aa * bb;
    endfunction

    // Accept cycle to first out_valid cycle.
    function automatic int exp_lat(input logic [W-1:0] b);
`ifdef MANT_MULT_EARLY_TERM_EN
        int m;
        m = 0;
        for (int i = 0; i < W; i++) if (b[i]) m = i + 1;
        if (m == 0) m = 1;
        return m + 2;
`else
        return W + 2;
`endif
    endfunction

    function automatic logic [W-1:0] rand_b();
        logic [W-1:0] full;
        full = W'($urandom);
        return full >> $urandom_range(0, W - 1);
    endfunction

    task automatic wait_in_ready(input string name);
        for (int i = 0; i < 64 && bus.in_ready !== 1'b1; i++) @(negedge clk);
        n_checks++;
        if (bus.in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL %s wait_in_ready: in_ready=%b required 1", name, bus.in_ready);
        end
    endtask

    task automatic do_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [PW-1:0] exp_p;
        int lat;
        bit seen;
        exp_p = ref_mul(a, b);
        wait_in_ready(name);
        bus.a_mant    = a;
        bus.b_mant    = b;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 100) begin
            @(negedge clk);
            lat++;
            bus.in_valid = 1'b0;
            bus.a_mant   = W'($urandom);
            bus.b_mant   = W'($urandom);
            if (bus.out_valid === 1'b1) seen = 1'b1;
        end
        n_checks++;
        if (!seen || lat != exp_lat(b)) begin
            n_errors++;
            $display("FAIL %s latency: got %0d (seen=%0b) required %0d", name, lat, seen, exp_lat(b));
        end
        n_checks++;
        if (bus.product !== exp_p) begin
            n_errors++;
            $display("FAIL %s product: got %h required %h", name, bus.product, exp_p);
        end
        @(negedge clk);
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL %s pulse: out_valid=%b required 0", name, bus.out_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (bus.in_ready !== 1'b1) begin
            n_errors++; $display("FAIL reset in_ready: got %b required 1", bus.in_ready);
        end
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_errors++; $display("FAIL reset out_valid: got %b required 0", bus.out_valid);
        end
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_errors++; $display("FAIL reset busy: got %b required 0", bus.busy);
        end
        n_checks++;
        if (bus.product !== '0) begin
            n_errors++; $display("FAIL reset product: got %h required 0", bus.product);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        do_op("c00000_sq", 24'hC00000, 24'hC00000);
        do_op("all_ones", 24'hFFFFFF, 24'hFFFFFF);
        do_op("b_one", 24'hABCDEF, 24'h000001);
        do_op("b_zero", 24'hABCDEF, 24'h000000);
        do_op("a_zero", 24'h000000, 24'h9A5C31);
    endtask

    task automatic test_random();
        for (int i = 0; i < 16; i++) do_op("random", W'($urandom), rand_b());
    endtask

    task automatic test_backpressure();
        logic [PW-1:0] exp_p;
        bit seen;
        exp_p = ref_mul(24'h800000, 24'h800000);
        wait_in_ready("bp");
        bus.a_mant    = 24'h800000;
        bus.b_mant    = 24'h800000;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            if (bus.out_valid === 1'b1) seen = 1'b1;
        end
        n_checks++;
        if (!seen) begin
            n_errors++; $display("FAIL bp out_valid: never seen, required 1");
        end
        for (int i = 0; i < 10; i++) begin
            // Offer a new operand during DONE; it must not be taken.
            bus.in_valid = 1'b1;
            bus.a_mant   = W'($urandom);
            bus.b_mant   = W'($urandom);
            n_checks++;
            if (bus.product !== exp_p || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
                n_errors++;
                $display("FAIL bp hold[%0d]: product=%h out_valid=%b in_ready=%b required %h 1 0",
                         i, bus.product, bus.out_valid, bus.in_ready, exp_p);
            end
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        n_checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
            n_errors++;
            $display("FAIL bp release: in_ready=%b out_valid=%b busy=%b required 1 0 0",
                     bus.in_ready, bus.out_valid, bus.busy);
        end
        @(negedge clk);
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_errors++; $display("FAIL bp no_accept: busy=%b required 0", bus.busy);
        end
    endtask

    task automatic test_reset_mid();
        bit pulse;
        wait_in_ready("mid_reset");
        bus.a_mant    = 24'h123456;
        bus.b_mant    = 24'hFEDCBA;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (11) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.product !== '0) begin
            n_errors++;
            $display("FAIL mid_reset state: in_ready=%b busy=%b out_valid=%b product=%h required 1 0 0 0",
                     bus.in_ready, bus.busy, bus.out_valid, bus.product);
        end
        pulse = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) pulse = 1'b1;
        end
        n_checks++;
        if (pulse) begin
            n_errors++; $display("FAIL mid_reset quiet: activity seen=1 required 0");
        end
        do_op("mid_reset_new", 24'h800001, 24'h800000);
    endtask

    task automatic test_back_to_back();
        logic [PW-1:0] exp_q[$];
        logic [PW-1:0] exp_p;
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        int cyc;
        int last_acc;
        int last_lat;
        int results;
        cyc      = 0;
        last_acc = -1;
        last_lat = 0;
        results  = 0;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        while (results < 4 && cyc < 400) begin
            if (bus.out_valid === 1'b1) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_errors++; $display("FAIL b2b unexpected: out_valid with empty queue");
                end else begin
                    exp_p = exp_q.pop_front();
                    if (bus.product !== exp_p) begin
                        n_errors++;
                        $display("FAIL b2b product: got %h required %h", bus.product, exp_p);
                    end
                end
                results++;
            end
            a = W'($urandom);
            b = rand_b();
            bus.a_mant = a;
            bus.b_mant = b;
            if (bus.in_ready === 1'b1) begin
                if (last_acc >= 0) begin
                    n_checks++;
                    if (cyc - last_acc != last_lat + 1) begin
                        n_errors++;
                        $display("FAIL b2b spacing: got %0d required %0d", cyc - last_acc, last_lat + 1);
                    end
                end
                exp_q.push_back(ref_mul(a, b));
                last_acc = cyc;
                last_lat = exp_lat(b);
            end
            @(negedge clk);
            cyc++;
        end
        bus.in_valid = 1'b0;
        n_checks++;
        if (results != 4) begin
            n_errors++; $display("FAIL b2b timeout: results=%0d required 4", results);
        end
        for (int i = 0; i < 64 && bus.busy !== 1'b0; i++) @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.a_mant    = '0;
        bus.b_mant    = '0;
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/mant_mult_seq.md
Name: mant_mult_seq

Overview:
- Sequential mantissa multiplier controller for the FP multiply path.
- Reduces WIDTH partial products one per cycle into a carry-save sum/carry pair using a single 3:2 compressor row, then resolves the pair with one carry-propagate add.
- Sits between operand unpack and normalise/round; trades latency for the area of a full compressor tree.
- Valid/ready handshake on both sides.

Parameters:
- WIDTH, 24, mantissa width including hidden bit; product is 2*WIDTH bits.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operands present
- in_ready  output  1  block can accept operands
- a_mant  input  WIDTH  multiplicand mantissa
- b_mant  input  WIDTH  multiplier mantissa
- out_valid  output  1  product valid
- out_ready  input  1  downstream accepts product
- product  output  2*WIDTH  unsigned a_mant*b_mant
- busy  output  1  high in any state except IDLE

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst).
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, product=0, count=0, sum=0, carry=0.
- FSM states: IDLE, REDUCE, RESOLVE, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, latch a_mant into a_reg and b_mant into b_sh, clear sum/carry/count, go to REDUCE.
- REDUCE, one partial product per cycle:
  - pp = b_sh[0] ? (a_reg << count) : 0, width 2*WIDTH.
  - {sum, carry} <= 3:2 row(sum, carry, pp), with the carry output shifted left 1 and truncated to 2*WIDTH bits.
  - b_sh >>= 1; count++.
  - Exit to RESOLVE on the cycle where count==WIDTH-1 is processed, i.e. exactly WIDTH cycles.
- RESOLVE: product <= sum + carry, truncated to 2*WIDTH bits (never overflows for unsigned WIDTH-bit operands). Go to DONE.
- DONE:
  - out_valid=1; product held stable while out_valid && !out_ready.
  - On out_ready, go to IDLE and drop out_valid on the next cycle.
- Latency: operands accepted at edge t → out_valid high from edge t+WIDTH+1, i.e. WIDTH+2 cycles including the accept cycle.
- Throughput: one result per WIDTH+3 cycles with out_ready held high; in_ready is 0 in REDUCE, RESOLVE and DONE.
- Input changes while busy are ignored; operands are latched only at accept.
- in_valid in DONE is not accepted until the state returns to IDLE.
- out_ready asserted outside DONE has no effect.
- rst in any state, including mid-REDUCE or DONE with a pending product: next cycle is IDLE with all reset values; the partial result is discarded and no out_valid pulse appears.
- Zero operands: a_mant=0 or b_mant=0 gives product=0 with normal latency.

Optional Feature:
- Macro: MANT_MULT_EARLY_TERM_EN.
- When defined:
  - REDUCE also exits to RESOLVE after processing a cycle in which (b_sh>>1)==0, i.e. no remaining multiplier bits are set.
  - Reduce cycles = max(1, index of MSB set in b_mant + 1).
  - Latency = reduce cycles + 2.
  - Result is identical to the non-early path.
- When undefined: fixed WIDTH reduce cycles; the logic is not present.

Test Plan:
- a=0xC00000, b=0xC00000, out_ready=1 → product=0x900000000000; out_valid exactly 26 cycles after accept; 1-cycle pulse.
- a=0xFFFFFF, b=0xFFFFFF → product=0xFFFFFE000001.
- Backpressure: a=0x800000, b=0x800000, out_ready=0 for 10 cycles after out_valid:
  - product=0x400000000000 held stable, in_ready=0 throughout;
  - after out_ready=1, IDLE next cycle.
- Reset mid-op: assert rst at reduce cycle 12 → next cycle in_ready=1, busy=0, out_valid=0; a new op a=0x800001, b=0x800000 then yields 0x400000800000.
- Back-to-back ops with in_valid held high → accepts spaced 27 cycles apart; in_valid while busy is not accepted; each product is correct.
- With MANT_MULT_EARLY_TERM_EN: a=0xABCDEF, b=0x000001 → product=0x000000ABCDEF, out_valid 3 cycles after accept. With b=0x000000 → product 0, latency 3. Without the macro, both cases take 26 cycles.
